// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_fwd_unit: EX operand forwarding selects and load-use stall FSM     |
// | with shadow EX/MEM/WB destination tracking. Optional HZD_WB_BYPASS_EN     |
// | adds id_rf_byp_o (WB->ID regfile write-through hint).                     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module hazard_fwd_unit #(
  parameter int NSRC     = 2,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze_i,
  input  logic                 flush_i,
  input  logic                 id_valid_i,
  input  logic [NSRC*AW-1:0]   id_src_i,
  input  logic [AW-1:0]        id_dest_i,
  input  logic                 id_regwrite_i,
  input  logic                 id_is_load_i,
  output logic [NSRC*2-1:0]    fwd_sel_o,
  output logic                 stall_o,
  output logic                 ex_bubble_o
`ifdef HZD_WB_BYPASS_EN
  ,
  output logic [NSRC-1:0]      id_rf_byp_o
`endif
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_STALL = 1'b1
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              stall;

  logic              ex_valid_q, ex_regwrite_q, ex_is_load_q;
  logic [AW-1:0]     ex_dest_q;
  logic [NSRC*AW-1:0] ex_src_q;
  logic              mem_valid_q, mem_regwrite_q, mem_is_load_q;
  logic [AW-1:0]     mem_dest_q;
  logic              wb_valid_q, wb_regwrite_q;
  logic [AW-1:0]     wb_dest_q;

  logic              ex_qual, mem_qual, wb_qual;
  logic [NSRC-1:0]   src_match;
  logic              hazard;

  assign ex_qual  = ex_valid_q  & ex_regwrite_q  & (ex_dest_q  != '0);
  assign mem_qual = mem_valid_q & mem_regwrite_q & (mem_dest_q != '0);
  assign wb_qual  = wb_valid_q  & wb_regwrite_q  & (wb_dest_q  != '0);

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    logic [AW-1:0] id_s;
    logic [AW-1:0] ex_s;
    logic [1:0]    sel;

    assign id_s = id_src_i[k*AW +: AW];
    assign ex_s = ex_src_q[k*AW +: AW];
    assign src_match[k] = (id_s != '0) & (id_s == ex_dest_q);

    // A load still in MEM has no data yet, so it must not be forwarded from EX/MEM.
    always_comb begin
      sel = 2'b00;
      if (ex_s == '0) begin
        sel = 2'b00;
      end else if (mem_qual && !mem_is_load_q && (mem_dest_q == ex_s)) begin
        sel = 2'b10;
      end else if (wb_qual && (wb_dest_q == ex_s)) begin
        sel = 2'b01;
      end
    end

    assign fwd_sel_o[k*2 +: 2] = sel;

`ifdef HZD_WB_BYPASS_EN
    assign id_rf_byp_o[k] = wb_qual & (wb_dest_q == id_s) & (id_s != '0);
`endif
  end

  assign hazard = id_valid_i & ex_qual & ex_is_load_q & (|src_match);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = hazard & ~flush_i;
        if (stall && (LOAD_LAT > 1)) begin
          state_d = S_STALL;
          cnt_d   = CNT_INIT;
        end
      end
      S_STALL: begin
        if (flush_i) begin
          state_d = S_IDLE;
          cnt_d   = 2'd0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
    end else if (!freeze_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_is_load_q   <= 1'b0;
      ex_dest_q      <= '0;
      ex_src_q       <= '0;
      mem_valid_q    <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_is_load_q  <= 1'b0;
      mem_dest_q     <= '0;
      wb_valid_q     <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_dest_q      <= '0;
    end else if (!freeze_i) begin
      wb_valid_q     <= mem_valid_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_dest_q      <= mem_dest_q;
      mem_valid_q    <= ex_valid_q;
      mem_regwrite_q <= ex_regwrite_q;
      mem_is_load_q  <= ex_is_load_q;
      mem_dest_q     <= ex_dest_q;
      ex_valid_q     <= id_valid_i & ~stall & ~flush_i;
      ex_regwrite_q  <= id_regwrite_i;
      ex_is_load_q   <= id_is_load_i;
      ex_dest_q      <= id_dest_i;
      ex_src_q       <= id_src_i;
    end
  end

  assign stall_o     = stall;
  assign ex_bubble_o = ~ex_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hazard_fwd_unit: random + directed bench for hazard_fwd_unit           |
// | (LOAD_LAT=1/NSRC=2 and LOAD_LAT=3/NSRC=3 instances, shared stimulus).     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_hazard_fwd_unit;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            freeze, flush, id_valid, id_regwrite, id_is_load;
  logic [3*AW-1:0] id_src;
  logic [AW-1:0]   id_dest;
  logic [3:0]      fwd1;
  logic [5:0]      fwd3;
  logic            stall1, stall3, bub1, bub3;
`ifdef HZD_WB_BYPASS_EN
  logic [1:0]      byp1;
  logic [2:0]      byp3;
`endif

  hazard_fwd_unit #(.NSRC(2), .AW(AW), .LOAD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .freeze_i(freeze), .flush_i(flush),
    .id_valid_i(id_valid), .id_src_i(id_src[2*AW-1:0]), .id_dest_i(id_dest),
    .id_regwrite_i(id_regwrite), .id_is_load_i(id_is_load),
    .fwd_sel_o(fwd1), .stall_o(stall1), .ex_bubble_o(bub1)
`ifdef HZD_WB_BYPASS_EN
    , .id_rf_byp_o(byp1)
`endif
  );

  hazard_fwd_unit #(.NSRC(3), .AW(AW), .LOAD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .freeze_i(freeze), .flush_i(flush),
    .id_valid_i(id_valid), .id_src_i(id_src), .id_dest_i(id_dest),
    .id_regwrite_i(id_regwrite), .id_is_load_i(id_is_load),
    .fwd_sel_o(fwd3), .stall_o(stall3), .ex_bubble_o(bub3)
`ifdef HZD_WB_BYPASS_EN
    , .id_rf_byp_o(byp3)
`endif
  );

  // Reference pipeline: one instruction record per stage, per instance.
  typedef struct packed {
    logic            v;
    logic [AW-1:0]   dest;
    logic            rw;
    logic            ld;
    logic [3*AW-1:0] src;
  } instr_t;

  instr_t m_ex[2], m_mem[2], m_wb[2];
  int     owed[2];
  int     lat[2]  = '{1, 3};
  int     nsrc[2] = '{2, 3};
  int     n_vec = 0, n_err = 0;
  logic   last_stall3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit qual(input instr_t i);
    return i.v && i.rw && (i.dest != 0);
  endfunction

  function automatic logic [AW-1:0] src_of(input logic [3*AW-1:0] s, input int k);
    return s[k*AW +: AW];
  endfunction

  function automatic logic [1:0] exp_fwd(input int d, input int k);
    logic [AW-1:0] s;
    s = src_of(m_ex[d].src, k);
    if (s == 0) return 2'b00;
    if (qual(m_mem[d]) && !m_mem[d].ld && m_mem[d].dest == s) return 2'b10;
    if (qual(m_wb[d]) && m_wb[d].dest == s) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit exp_stall(input int d);
    if (flush) return 1'b0;
    if (owed[d] > 0) return 1'b1;
    if (!id_valid || !qual(m_ex[d]) || !m_ex[d].ld) return 1'b0;
    for (int k = 0; k < nsrc[d]; k++)
      if (src_of(id_src, k) != 0 && src_of(id_src, k) == m_ex[d].dest) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] obs_fwd(input int d, input int k);
    logic [5:0] v;
    v = (d == 0) ? {2'b00, fwd1} : fwd3;
    return v[k*2 +: 2];
  endfunction

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      m_ex[d] = '0; m_mem[d] = '0; m_wb[d] = '0; owed[d] = 0;
    end
  endtask

  // Entered at a negedge with inputs applied; returns at the next negedge.
  task automatic cyc();
    bit es[2];
    #1;
    for (int d = 0; d < 2; d++) begin
      es[d] = exp_stall(d);
      chk($sformatf("d%0d stall", d), (d == 0) ? 32'(stall1) : 32'(stall3), 32'(es[d]));
      chk($sformatf("d%0d ex_bubble", d), (d == 0) ? 32'(bub1) : 32'(bub3), 32'(!m_ex[d].v));
      for (int k = 0; k < nsrc[d]; k++)
        chk($sformatf("d%0d fwd_sel%0d", d, k), 32'(obs_fwd(d, k)), 32'(exp_fwd(d, k)));
`ifdef HZD_WB_BYPASS_EN
      for (int k = 0; k < nsrc[d]; k++) begin
        logic ob;
        ob = (d == 0) ? byp1[k] : byp3[k];
        chk($sformatf("d%0d byp%0d", d, k), 32'(ob),
            32'(qual(m_wb[d]) && src_of(id_src, k) != 0 && m_wb[d].dest == src_of(id_src, k)));
      end
`endif
    end
    last_stall3 = stall3;
    @(posedge clk);
    if (!freeze) begin
      for (int d = 0; d < 2; d++) begin
        if (flush) owed[d] = 0;
        else if (owed[d] > 0) owed[d]--;
        else if (es[d]) owed[d] = lat[d] - 1;
        m_wb[d]  = m_mem[d];
        m_mem[d] = m_ex[d];
        m_ex[d]  = '{v: id_valid && !es[d] && !flush, dest: id_dest,
                     rw: id_regwrite, ld: id_is_load, src: id_src};
      end
    end
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input int dest, input logic rw, input logic ld,
                        input int s0, input int s1, input int s2);
    id_valid = v; id_dest = AW'(dest); id_regwrite = rw; id_is_load = ld;
    id_src = {AW'(s2), AW'(s1), AW'(s0)};
    freeze = 1'b0; flush = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0);
    mreset();
    #1;
    chk("rst stall1", 32'(stall1), 0);
    chk("rst stall3", 32'(stall3), 0);
    chk("rst bub1", 32'(bub1), 1);
    chk("rst bub3", 32'(bub3), 1);
    chk("rst fwd1", 32'(fwd1), 0);
    chk("rst fwd3", 32'(fwd3), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // addi x5 ; add x6,x5,x1 ; nop ; add x0 ; read x0 repeatedly
    set_id(1, 5, 1, 0, 1, 0, 0); cyc();
    set_id(1, 6, 1, 0, 5, 1, 0); cyc();
    set_id(1, 9, 1, 0, 2, 3, 0); cyc();
    set_id(1, 4, 1, 0, 5, 0, 0); cyc();
    set_id(1, 0, 1, 0, 1, 2, 0); cyc();
    repeat (4) begin set_id(1, 3, 1, 0, 0, 0, 0); cyc(); end

    // lw x7 ; add x8,x7,x7 held in ID, freeze two cycles mid-stall
    set_id(1, 7, 1, 1, 1, 0, 0); cyc();
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      set_id(1, 8, 1, 0, 7, 7, 0);
      freeze = (i == 1 || i == 2);
      cyc();
      cnt += int'(last_stall3);
    end
    chk("lat3 stall cycles", 32'(cnt), 5);

    // flush while in STALL
    set_id(1, 7, 1, 1, 0, 0, 0); cyc();
    set_id(1, 8, 1, 0, 0, 7, 7); cyc();
    set_id(1, 8, 1, 0, 0, 7, 7); flush = 1'b1; cyc();
    repeat (3) begin set_id(1, 2, 1, 0, 1, 1, 1); cyc(); end

    // async reset mid-stall
    set_id(1, 7, 1, 1, 0, 0, 0); cyc();
    set_id(1, 8, 1, 0, 7, 0, 0); cyc();
    #1;
    chk("pre-rst stall3", 32'(stall3), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst stall3", 32'(stall3), 0);
    chk("midrst stall1", 32'(stall1), 0);
    chk("midrst bub3", 32'(bub3), 1);
    chk("midrst fwd3", 32'(fwd3), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mreset();

    for (int i = 0; i < 3000; i++) begin
      id_valid    = ($urandom_range(0, 7) != 0);
      id_dest     = AW'($urandom_range(0, 3));
      id_regwrite = ($urandom_range(0, 3) != 0);
      id_is_load  = ($urandom_range(0, 2) == 0);
      id_src      = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
      freeze      = ($urandom_range(0, 9) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
